// File: rtl/mp_addsub_seq_pkg.sv
// Shared types, defaults and helpers for the multi-precision add/sub sequencer.
package mp_addsub_pkg;

  // Default word width and maximum word count
  localparam int unsigned M_DEF    = 32;
  localparam int unsigned MAXW_DEF = 8;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Clamp a requested word count to the supported maximum
  function automatic int unsigned sat_nwords(input int unsigned n, input int unsigned maxw);
    return (n > maxw) ? maxw : n;
  endfunction

endpackage

// File: rtl/mp_addsub_seq_if.sv
// Front-end bus of the sequencer: command, operand stream, result stream and flags.
interface mp_addsub_seq_if #(
  parameter int unsigned M    = mp_addsub_pkg::M_DEF,
  parameter int unsigned MAXW = mp_addsub_pkg::MAXW_DEF
);
  localparam int unsigned CW = $clog2(MAXW + 1);

  // Command
  logic          start;
  logic          sub;
  logic [CW-1:0] nwords;
  logic          busy;
  // Operand stream
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  x;
  logic [M-1:0]  y;
  // Result stream
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out;
  logic          out_last;
  // Completion and flags
  logic          done;
  logic          cout;
  logic          v;
  logic          zero;

  modport master (
    output start, sub, nwords, in_valid, x, y, out_ready,
    input  busy, in_ready, out_valid, out, out_last, done, cout, v, zero
  );

  modport slave (
    input  start, sub, nwords, in_valid, x, y, out_ready,
    output busy, in_ready, out_valid, out, out_last, done, cout, v, zero
  );

endinterface

// File: rtl/mp_addsub_seq_cla.sv
// M-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// cin/cout are borrow-sense when sub = 1, so chaining cout -> cin works in both modes.
module claAddSub32Pow4 #(
  parameter int unsigned M = 32
) (
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  input  logic         sub,
  input  logic         cin,
  output logic [M-1:0] sum,
  output logic         cout,
  output logic         v,
  output logic         g,
  output logic         p
);
  localparam int unsigned NG = M / 4;

  logic [M-1:0]  yy;
  logic [M-1:0]  bg;
  logic [M-1:0]  bp;
  logic [M:0]    c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;

  assign yy = y ^ {M{sub}};
  assign bg = x & yy;
  assign bp = x ^ yy;

  // In-group lookahead carries, group generate/propagate rippled between groups
  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    // Internal carry-in is inverted for subtraction (borrow 0 == carry 1)
    c[0] = cin ^ sub;
    for (int k = 0; k < NG; k++) begin
      c[4*k+1] = bg[4*k] | (bp[4*k] & c[4*k]);
      c[4*k+2] = bg[4*k+1] | (bp[4*k+1] & bg[4*k]) | (bp[4*k+1] & bp[4*k] & c[4*k]);
      c[4*k+3] = bg[4*k+2] | (bp[4*k+2] & bg[4*k+1]) | (bp[4*k+2] & bp[4*k+1] & bg[4*k])
               | (bp[4*k+2] & bp[4*k+1] & bp[4*k] & c[4*k]);
      gg[k] = bg[4*k+3] | (bp[4*k+3] & bg[4*k+2]) | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
            | (bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bg[4*k]);
      gp[k] = bp[4*k+3] & bp[4*k+2] & bp[4*k+1] & bp[4*k];
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
  end

  // Whole-word generate/propagate for use by an outer lookahead level
  always_comb begin
    g = 1'b0;
    p = 1'b1;
    for (int k = 0; k < NG; k++) begin
      g = gg[k] | (gp[k] & g);
      p = p & gp[k];
    end
  end

  assign sum  = bp ^ c[M-1:0];
  assign cout = c[M] ^ sub;
  assign v    = c[M] ^ c[M-1];

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: streams words LS-first through one M-bit
// adder, carrying the inter-word carry/borrow in a register.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int unsigned M    = M_DEF,
  parameter int unsigned MAXW = MAXW_DEF
) (
  input logic              clk,
  input logic              rst,
  mp_addsub_seq_if.slave   bus
);
  localparam int unsigned CW = $clog2(MAXW + 1);

  state_t        state_q, state_d;
  logic          sub_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] issued_q;
  logic          c_q;
  logic          zacc_q;
  logic [M-1:0]  out_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          cout_q;
  logic          v_q;
  logic          zero_q;

  logic          start_acc;
  logic          in_ready;
  logic          in_hs;
  logic          out_hs;
  logic          is_last;
  logic [M-1:0]  add_sum;
  logic          add_cout;
  logic          add_v;
  logic          sum_zero;

  claAddSub32Pow4 #(.M(M)) u_cla (
    .x    (bus.x),
    .y    (bus.y),
    .sub  (sub_q),
    .cin  (c_q),
    .sum  (add_sum),
    .cout (add_cout),
    .v    (add_v),
    .g    (),
    .p    ()
  );

  // Handshake and word-position decode
  always_comb begin
    start_acc = (state_q == IDLE) && bus.start;
    // Single output register: accept only if it is empty or draining this cycle
    in_ready  = (state_q == RUN) && (issued_q < n_q) && (!out_valid_q || bus.out_ready);
    in_hs     = bus.in_valid && in_ready;
    out_hs    = out_valid_q && bus.out_ready;
    is_last   = ((issued_q + CW'(1)) == n_q);
    sum_zero  = (add_sum == '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.nwords == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (out_hs && out_last_q) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture, carry chain, word counter and flag accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q    <= 1'b0;
      n_q      <= '0;
      issued_q <= '0;
      c_q      <= 1'b0;
      zacc_q   <= 1'b0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      zero_q   <= 1'b0;
    end else if (start_acc) begin
      sub_q    <= bus.sub;
      n_q      <= CW'(sat_nwords(32'(bus.nwords), MAXW));
      issued_q <= '0;
      c_q      <= 1'b0;
      zacc_q   <= 1'b1;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      // An empty operation is trivially all-zero
      zero_q   <= (bus.nwords == '0);
    end else if (in_hs) begin
      issued_q <= issued_q + CW'(1);
      c_q      <= add_cout;
      zacc_q   <= zacc_q & sum_zero;
      if (is_last) begin
        cout_q <= add_cout;
        v_q    <= add_v;
        zero_q <= zacc_q & sum_zero;
      end
    end
  end

  // Result output register; a load in the drain cycle keeps it full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (in_hs) begin
      out_q       <= add_sum;
      out_valid_q <= 1'b1;
      out_last_q  <= is_last;
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign bus.busy      = (state_q != IDLE) && (state_q != FIN);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = (state_q == FIN);
  assign bus.cout      = cout_q;
  assign bus.v         = v_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: vector table plus scoreboarded corner sequences.
module tb_mp_addsub_seq;

  localparam int unsigned M    = 32;
  localparam int unsigned MAXW = 8;
  localparam int unsigned CW   = 4;
  localparam int          NV   = 7;

  typedef struct {
    bit              s;
    int              n;
    logic [1:0][31:0] x;
    logic [1:0][31:0] y;
    logic [1:0][31:0] e;
    bit              co;
    bit              ov;
    bit              z;
  } vec_t;

  logic clk;
  logic rst;

  mp_addsub_seq_if #(.M(M), .MAXW(MAXW)) bus ();

  mp_addsub_seq #(.M(M), .MAXW(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] vx   [8];
  logic [31:0] vy   [8];
  logic [31:0] vexp [8];
  bit          ecout, ev, ezero;
  logic [31:0] sb_q [$];
  vec_t        vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: word-serial add/sub with a plain integer carry
  task automatic model(input bit s, input int n);
    logic        ci;
    logic [32:0] r;
    logic [31:0] yy;
    logic [31:0] lo;
    ci = s;
    ezero = 1'b1;
    ecout = 1'b0;
    ev = 1'b0;
    for (int w = 0; w < n; w++) begin
      yy = s ? ~vy[w] : vy[w];
      r  = {1'b0, vx[w]} + {1'b0, yy} + 33'(ci);
      lo = {1'b0, vx[w][30:0]} + {1'b0, yy[30:0]} + 32'(ci);
      vexp[w] = r[31:0];
      ezero = ezero & (r[31:0] == 32'h0);
      if (w == n - 1) begin
        ecout = r[32] ^ s;
        ev    = r[32] ^ lo[31];
      end
      ci = r[32];
    end
  endtask

  // One complete operation; expected words from vexp, flags from ecout/ev/ezero
  task automatic run_op(input bit s, input int n_req, input int stall_after,
                        input int stall_len, input bit mid_start);
    int          n_eff;
    int          issued;
    int          seen;
    int          stall_cnt;
    int          cyc;
    bit          fin;
    bit          stalling;
    bit          prev_stall;
    bit          mid_fired;
    logic [31:0] held;
    n_eff = (n_req > 8) ? 8 : n_req;
    issued = 0; seen = 0; stall_cnt = 0; cyc = 0;
    fin = 0; prev_stall = 0; mid_fired = 0; held = '0;
    sb_q.delete();

    @(posedge clk); #1;
    bus.start = 1'b1; bus.sub = s; bus.nwords = CW'(n_req);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.sub = ~s; bus.nwords = '0;

    if (n_eff == 0) begin
      chk("empty_done", 32'(bus.done), 1);
      chk("empty_busy", 32'(bus.busy), 0);
      chk("empty_out_valid", 32'(bus.out_valid), 0);
      chk("empty_cout", 32'(bus.cout), 32'(ecout));
      chk("empty_v", 32'(bus.v), 32'(ev));
      chk("empty_zero", 32'(bus.zero), 32'(ezero));
      fin = 1;
    end else begin
      chk("busy_after_start", 32'(bus.busy), 1);
    end

    while (!fin && cyc < 200) begin
      stalling = (seen >= stall_after) && (stall_cnt < stall_len);
      if (stalling) stall_cnt++;
      bus.out_ready = !stalling;
      bus.in_valid  = (issued < n_eff);
      bus.x = vx[(issued < 8) ? issued : 0];
      bus.y = vy[(issued < 8) ? issued : 0];
      bus.start = 1'b0;
      if (mid_start && !mid_fired && issued == 2) begin
        bus.start = 1'b1; bus.nwords = CW'(3); mid_fired = 1;
      end
      @(negedge clk);
      if (stalling && bus.out_valid) begin
        chk("stall_in_ready", 32'(bus.in_ready), 0);
        if (prev_stall) chk("stall_out_hold", bus.out, held);
      end
      held = bus.out;
      prev_stall = stalling;
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) chk("out_word", bus.out, sb_q.pop_front());
        chk("out_last", 32'(bus.out_last), 32'(seen == n_eff - 1));
        seen++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(vexp[issued]);
        issued++;
      end
      if (bus.done) begin
        fin = 1;
        chk("words_out", 32'(seen), 32'(n_eff));
        chk("sb_drained", 32'(sb_q.size()), 0);
        chk("done_busy", 32'(bus.busy), 0);
        chk("cout", 32'(bus.cout), 32'(ecout));
        chk("v", 32'(bus.v), 32'(ev));
        chk("zero", 32'(bus.zero), 32'(ezero));
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    if (!fin) chk("done_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("flags_hold_cout", 32'(bus.cout), 32'(ecout));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.nwords = '0;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b0;

    vecs[0] = '{s: 0, n: 2, x: {32'h0, 32'hFFFFFFFF}, y: {32'h0, 32'h1},
                e: {32'h1, 32'h0}, co: 0, ov: 0, z: 0};
    vecs[1] = '{s: 1, n: 2, x: {32'h0, 32'h0}, y: {32'h0, 32'h1},
                e: {32'hFFFFFFFF, 32'hFFFFFFFF}, co: 1, ov: 0, z: 0};
    vecs[2] = '{s: 1, n: 1, x: {32'h0, 32'h80000000}, y: {32'h0, 32'h1},
                e: {32'h0, 32'h7FFFFFFF}, co: 0, ov: 1, z: 0};
    vecs[3] = '{s: 0, n: 1, x: {32'h0, 32'h7FFFFFFF}, y: {32'h0, 32'h1},
                e: {32'h0, 32'h80000000}, co: 0, ov: 1, z: 0};
    vecs[4] = '{s: 0, n: 2, x: {32'h0, 32'h0}, y: {32'h0, 32'h0},
                e: {32'h0, 32'h0}, co: 0, ov: 0, z: 1};
    vecs[5] = '{s: 0, n: 1, x: {32'h0, 32'hFFFFFFFF}, y: {32'h0, 32'h1},
                e: {32'h0, 32'h0}, co: 1, ov: 0, z: 1};
    vecs[6] = '{s: 1, n: 1, x: {32'h0, 32'h5}, y: {32'h0, 32'h5},
                e: {32'h0, 32'h0}, co: 0, ov: 0, z: 1};

    #3;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out", bus.out, 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_flags", {29'b0, bus.cout, bus.v, bus.zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      for (int w = 0; w < 2; w++) begin
        vx[w] = vecs[i].x[w]; vy[w] = vecs[i].y[w]; vexp[w] = vecs[i].e[w];
      end
      ecout = vecs[i].co; ev = vecs[i].ov; ezero = vecs[i].z;
      run_op(vecs[i].s, vecs[i].n, 99, 0, 1'b0);
    end

    // 4-word add with carry ripple: unstalled, then stalled with a stray start
    vx[0] = 32'hFFFFFFFF; vy[0] = 32'h00000003;
    vx[1] = 32'hFFFFFFFF; vy[1] = 32'h00000000;
    vx[2] = 32'h12345678; vy[2] = 32'h9ABCDEF0;
    vx[3] = 32'h7FFFFFFF; vy[3] = 32'h00000000;
    model(1'b0, 4);
    run_op(1'b0, 4, 99, 0, 1'b0);
    run_op(1'b0, 4, 1, 3, 1'b1);

    // Empty operation
    model(1'b0, 0);
    run_op(1'b0, 0, 99, 0, 1'b0);

    // Oversized count saturates to MAXW; subtract with random words
    for (int w = 0; w < 8; w++) begin
      vx[w] = $urandom; vy[w] = $urandom;
    end
    model(1'b1, 8);
    run_op(1'b1, 12, 99, 0, 1'b0);

    // Reset mid-operation after 2 of 4 words
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sub = 1'b0; bus.nwords = CW'(4); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.x = 32'hFFFFFFFF; bus.y = 32'h1;
    @(posedge clk); #1;
    bus.x = 32'hFFFFFFFF; bus.y = 32'h1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_out", bus.out, 0);
    chk("arst_out_last", 32'(bus.out_last), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_flags", {29'b0, bus.cout, bus.v, bus.zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    vx[0] = 32'h5; vy[0] = 32'h3; vexp[0] = 32'h8;
    ecout = 1'b0; ev = 1'b0; ezero = 1'b0;
    run_op(1'b0, 1, 99, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
